// File: rtl/stream_demux.sv
// stream_demux: 1-to-NOUT packet demux, destination taken from in_sel on the first beat; 1-cycle latency.
// Backpressure: a held beat stalls the input until its destination drains it; dropped packets are always consumed.
// Optional: define STREAM_DEMUX_ERR_CNT_EN to add a saturating 16-bit err_count of dropped packets.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int NOUT  = 2,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [NOUT-1:0]  out_valid,
    input  logic [NOUT-1:0]  out_ready,
    output logic             drop_pulse
`ifdef STREAM_DEMUX_ERR_CNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    localparam logic [SEL_W:0] NOUT_V = NOUT[SEL_W:0];

    state_t           state;
    logic [SEL_W-1:0] dest;
    logic [NOUT-1:0]  sel_hot;
    logic [NOUT-1:0]  dest_hot;
    logic             full;
    logic             drain;
    logic             in_xfer;
    logic             sel_ok;
    logic             drop_now;

    // out_valid only ever carries the latched destination bit, so this equals out_ready[dest] when full.
    assign full     = |out_valid;
    assign drain    = |(out_valid & out_ready);
    assign in_ready = (state == DROP) | ~full | drain;
    assign in_xfer  = in_valid & in_ready;
    // An unknown select evaluates false here and is therefore dropped.
    assign sel_ok   = ({1'b0, in_sel} < NOUT_V);
    assign drop_now = in_xfer & (state == IDLE) & ~sel_ok;

    always_comb begin
        sel_hot  = '0;
        dest_hot = '0;
        for (int k = 0; k < NOUT; k++) begin
            sel_hot[k]  = (in_sel == SEL_W'(k));
            dest_hot[k] = (dest == SEL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dest       <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
            drop_pulse <= 1'b0;
`ifdef STREAM_DEMUX_ERR_CNT_EN
            err_count  <= 16'd0;
`endif
        end else begin
            drop_pulse <= drop_now;
            if (drain) begin
                out_valid <= '0;
            end
            if (in_xfer) begin
                unique case (state)
                    IDLE: begin
                        if (sel_ok) begin
                            dest      <= in_sel;
                            out_data  <= in_data;
                            out_last  <= in_last;
                            out_valid <= sel_hot;
                            state     <= in_last ? IDLE : ROUTE;
                        end else begin
                            state     <= in_last ? IDLE : DROP;
                        end
                    end
                    ROUTE: begin
                        out_data  <= in_data;
                        out_last  <= in_last;
                        out_valid <= dest_hot;
                        if (in_last) begin
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (in_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef STREAM_DEMUX_ERR_CNT_EN
            if (drop_now && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux (WIDTH=8, NOUT=2, SEL_W=2) with hand-computed expectations.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic       drop_pulse;
`ifdef STREAM_DEMUX_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8), .NOUT(2), .SEL_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse)
`ifdef STREAM_DEMUX_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic l, input logic v);
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        in_valid = v;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] v, input logic [7:0] d, input logic l);
        check({tag, ".valid"}, out_valid, v);
        if (v != 2'b00) begin
            check({tag, ".data"}, out_data, d);
            check({tag, ".last"}, out_last, l);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 2'b11;
        drive(8'h00, 2'd0, 1'b0, 1'b0);
        step();
        step();
        check("rst.valid", out_valid, 2'b00);
        check("rst.data", out_data, 8'h00);
        check("rst.last", out_last, 1'b0);
        check("rst.drop", drop_pulse, 1'b0);
        check("rst.in_ready", in_ready, 1'b1);
`ifdef STREAM_DEMUX_ERR_CNT_EN
        check("rst.err_count", err_count, 16'd0);
`endif
        rst = 1'b0;

        // 3-beat packet to port 1, all outputs ready
        drive(8'hA1, 2'd1, 1'b0, 1'b1);
        step();
        expect_out("t1.b1", 2'b10, 8'hA1, 1'b0);
        check("t1.b1.drop", drop_pulse, 1'b0);
        drive(8'hA2, 2'd1, 1'b0, 1'b1);
        check("t1.b2.in_ready", in_ready, 1'b1);
        step();
        expect_out("t1.b2", 2'b10, 8'hA2, 1'b0);
        drive(8'hA3, 2'd1, 1'b1, 1'b1);
        step();
        expect_out("t1.b3", 2'b10, 8'hA3, 1'b1);
        check("t1.b3.drop", drop_pulse, 1'b0);
        drive(8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check("t1.idle.valid", out_valid, 2'b00);

        // Port 0 stalled for 4 cycles
        out_ready = 2'b10;
        drive(8'hA1, 2'd0, 1'b0, 1'b1);
        step();
        expect_out("t2.b1", 2'b01, 8'hA1, 1'b0);
        drive(8'hA2, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t2.stall.in_ready", in_ready, 1'b0);
            step();
            expect_out("t2.stall", 2'b01, 8'hA1, 1'b0);
        end
        out_ready = 2'b11;
        #1;
        check("t2.release.in_ready", in_ready, 1'b1);
        step();
        expect_out("t2.b2", 2'b01, 8'hA2, 1'b0);
        drive(8'hA3, 2'd0, 1'b1, 1'b1);
        check("t2.b3.in_ready", in_ready, 1'b1);
        step();
        expect_out("t2.b3", 2'b01, 8'hA3, 1'b1);
        drive(8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check("t2.idle.valid", out_valid, 2'b00);

        // Back-to-back single-beat packets to different ports
        drive(8'h11, 2'd0, 1'b1, 1'b1);
        step();
        expect_out("t3.p0", 2'b01, 8'h11, 1'b1);
        drive(8'h22, 2'd1, 1'b1, 1'b1);
        check("t3.p1.in_ready", in_ready, 1'b1);
        step();
        expect_out("t3.p1", 2'b10, 8'h22, 1'b1);
        drive(8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check("t3.idle.valid", out_valid, 2'b00);

        // Out-of-range select: 2-beat packet dropped, then a normal packet
        drive(8'h55, 2'd3, 1'b0, 1'b1);
        check("t4.b1.in_ready", in_ready, 1'b1);
        step();
        check("t4.b1.drop", drop_pulse, 1'b1);
        check("t4.b1.valid", out_valid, 2'b00);
        drive(8'h56, 2'd0, 1'b1, 1'b1);
        check("t4.b2.in_ready", in_ready, 1'b1);
        step();
        check("t4.b2.drop", drop_pulse, 1'b0);
        check("t4.b2.valid", out_valid, 2'b00);
        drive(8'h66, 2'd0, 1'b1, 1'b1);
        step();
        expect_out("t4.next", 2'b01, 8'h66, 1'b1);
        check("t4.next.drop", drop_pulse, 1'b0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
        check("t4.err_count", err_count, 16'd1);
`endif
        drive(8'h00, 2'd0, 1'b0, 1'b0);
        step();

        // Reset during beat 2 of a stalled packet
        out_ready = 2'b00;
        drive(8'hB1, 2'd0, 1'b0, 1'b1);
        step();
        expect_out("t5.b1", 2'b01, 8'hB1, 1'b0);
        drive(8'hB2, 2'd0, 1'b0, 1'b1);
        check("t5.b2.in_ready", in_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5.rst.valid", out_valid, 2'b00);
        check("t5.rst.data", out_data, 8'h00);
        out_ready = 2'b11;
        drive(8'hC1, 2'd1, 1'b1, 1'b1);
        check("t5.new.in_ready", in_ready, 1'b1);
        step();
        expect_out("t5.new", 2'b10, 8'hC1, 1'b1);
        drive(8'h00, 2'd0, 1'b0, 1'b0);
        step();

        // Select changes mid-packet are ignored
        drive(8'hD1, 2'd0, 1'b0, 1'b1);
        step();
        expect_out("t6.b1", 2'b01, 8'hD1, 1'b0);
        drive(8'hD2, 2'd1, 1'b0, 1'b1);
        step();
        expect_out("t6.b2", 2'b01, 8'hD2, 1'b0);
        drive(8'hD3, 2'd1, 1'b1, 1'b1);
        step();
        expect_out("t6.b3", 2'b01, 8'hD3, 1'b1);
        drive(8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check("t6.idle.valid", out_valid, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Sequential 1-to-NOUT packet demultiplexer with a valid/ready handshake on every port.
- Steers each input packet to the output selected by in_sel, sampled on the packet's first beat. It is the receive-side counterpart of the team's combinational select-mux path.
- One registered output stage gives a fixed 1-cycle latency.
- Packets with an out-of-range select are consumed and discarded, and are flagged on drop_pulse.

Parameters:
- WIDTH, 8, data width in bits.
- NOUT, 2, number of output ports (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NOUT.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input beat data.
- in_sel  input  SEL_W  destination port; sampled on the first beat only.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  WIDTH  registered data, shared by all outputs.
- out_last  output  1  registered last flag, shared by all outputs.
- out_valid  output  NOUT  one-hot; only the destination bit can be set.
- out_ready  input  NOUT  per-output ready.
- drop_pulse  output  1  one-cycle pulse when a packet is dropped.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, out_valid=0, out_data=0, out_last=0, drop_pulse=0.
  - The latched destination and the error count are cleared.
  - A beat held mid-packet is discarded. Outputs are clean in the cycle after the reset edge.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output k transfer = out_valid[k] & out_ready[k].
  - out_valid stays asserted and out_data/out_last stay stable until the transfer; none of them depend combinationally on out_ready.
- Output register:
  - full = |out_valid. reg_dest = latched destination.
  - in_ready = (state==DROP) | ~full | out_ready[reg_dest]. This allows one beat per cycle under continuous ready.
- States:
  - IDLE (between packets):
    - On an input transfer with in_sel < NOUT: latch dest=in_sel, load the register, set out_valid[in_sel].
    - Then go to ROUTE if in_last=0, or stay in IDLE if in_last=1 (single-beat packet).
    - On an input transfer with in_sel >= NOUT: discard the beat, pulse drop_pulse, go to DROP if in_last=0, otherwise stay in IDLE.
  - ROUTE:
    - Each input transfer loads the register toward the latched dest; in_sel is ignored.
    - A transfer with in_last=1 returns to IDLE.
  - DROP:
    - in_ready=1; beats are consumed and discarded, out_valid is unaffected.
    - A transfer with in_last=1 returns to IDLE.
- Latency: exactly 1 cycle from input transfer to out_valid when the register is free. Backpressure on the current destination stalls the input.
- Back-to-back packets to different ports:
  - The new first beat may load in the same cycle the old last beat drains from the old dest.
  - Otherwise it waits; out_valid never has two bits set.
- Simultaneous drain and load: the register takes the new beat, and out_valid moves to the new destination bit.
- Unknown (X/Z) select in simulation: treated as out-of-range (drop). The RTL compares with in_sel < NOUT, so X makes the condition false.
- Draining a held beat does not depend on the input state; a beat already in the register drains normally while the FSM is in DROP.

Optional Feature:
- Macro: STREAM_DEMUX_ERR_CNT_EN.
- Defined:
  - Adds port err_count (output, 16 bits).
  - Increments on every drop_pulse and saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the port and counter are absent; drop_pulse is unchanged.

Test Plan:
- Reset, then a 3-beat packet with sel=1, data 8'hA1/A2/A3, out_ready=2'b11 -> out_valid=2'b10 on cycles 1-3, out_data A1,A2,A3, out_last=1 on A3 only; drop_pulse stays 0.
- Packet to sel=0 with out_ready[0]=0 for 4 cycles -> in_ready=0 while the register is full, out_data holds 8'hA1 stable. After ready rises, one beat per cycle.
- Back-to-back: 1-beat packet to sel=0 (8'h11), then 1-beat packet to sel=1 (8'h22), both outputs ready -> out_valid 01 then 10 on consecutive cycles; never 11.
- Drop: 2-beat packet with sel=3 (NOUT=2) -> drop_pulse=1 for 1 cycle, in_ready=1 on both beats, out_valid stays 0. Next packet with sel=0 routes normally. With the macro defined, err_count=1.
- Reset mid-packet: assert rst during beat 2 of a 3-beat packet while the output is stalled -> out_valid=0 the next cycle, state IDLE. A new 1-beat packet with sel=1 routes correctly.
- Select change mid-packet: beat 1 sel=0, beats 2-3 sel=1 -> all three beats appear on out_valid[0].
